// File: rtl/scurve_usb_framer.sv
// S-curve result framer: buffers the upstream 16-bit stream in a small FIFO
// and emits header/info/data/checksum/trailer frames into the USB data FIFO.
module scurve_usb_framer #(
  parameter int          DEPTH_LOG2 = 5,
  parameter int          FRAME_LEN  = 16,
  parameter logic [15:0] HEADER     = 16'hA55A,
  parameter logic [15:0] TRAILER    = 16'h5AA5
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Clear,
  input  logic        in_wr_en,
  input  logic [15:0] in_din,
  output logic        in_full,
  input  logic        Test_Done,
  input  logic [2:0]  Asic_ID,
  output logic        out_wr_en,
  output logic [15:0] out_din,
  input  logic        out_full,
  output logic        Flush_Done,
  output logic        Overflow
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0]         DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0]         FULL_C      = CW'(DEPTH - 2);
  localparam logic [CW-1:0]         FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_INFO, S_DATA, S_SUM, S_TAIL} state_t;

  state_t                r_state;
  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [7:0]            r_seq;
  logic [4:0]            r_len;
  logic [4:0]            r_sent;
  logic [15:0]           r_sum;
  logic                  r_flush_pending;

  state_t      w_state_nxt;
  logic        w_emit;
  logic [15:0] w_word;
  logic        w_pop;
  logic        w_start;
  logic [4:0]  w_start_len;
  logic        w_flush_done;
  logic        w_wr;
  logic        w_drop;

  assign w_wr    = in_wr_en && (r_count != DEPTH_C);
  assign w_drop  = in_wr_en && (r_count == DEPTH_C);
  assign in_full = (r_count >= FULL_C);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_emit       = 1'b0;
    w_word       = '0;
    w_pop        = 1'b0;
    w_start      = 1'b0;
    w_start_len  = '0;
    w_flush_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count >= FRAME_LEN_C) begin
          w_start     = 1'b1;
          w_start_len = 5'(FRAME_LEN);
        end else if (r_flush_pending && (r_count != '0)) begin
          w_start     = 1'b1;
          w_start_len = 5'(r_count);
        end else if (r_flush_pending) begin
          w_flush_done = 1'b1;
        end
        if (w_start) w_state_nxt = S_HEAD;
      end
      S_HEAD: begin
        w_word = HEADER;
        if (!out_full) begin w_emit = 1'b1; w_state_nxt = S_INFO; end
      end
      S_INFO: begin
        w_word = {Asic_ID, r_seq, r_len};
        if (!out_full) begin w_emit = 1'b1; w_state_nxt = S_DATA; end
      end
      S_DATA: begin
        w_word = r_mem[r_rd_ptr];
        if (!out_full) begin
          w_emit = 1'b1;
          w_pop  = 1'b1;
          if (r_sent == r_len - 5'd1) w_state_nxt = S_SUM;
        end
      end
      S_SUM: begin
        w_word = r_sum;
        if (!out_full) begin w_emit = 1'b1; w_state_nxt = S_TAIL; end
      end
      S_TAIL: begin
        w_word = TRAILER;
        if (!out_full) begin w_emit = 1'b1; w_state_nxt = S_IDLE; end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)   r_state <= S_IDLE;
    else if (Clear) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // NOTE: the buffer array carries no reset; count and pointers define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_din;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
      r_seq <= '0; r_len <= '0; r_sent <= '0; r_sum <= '0;
      r_flush_pending <= 1'b0;
      out_wr_en <= 1'b0; out_din <= '0; Flush_Done <= 1'b0; Overflow <= 1'b0;
    end else if (Clear) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
      r_seq <= '0; r_len <= '0; r_sent <= '0; r_sum <= '0;
      r_flush_pending <= 1'b0;
      out_wr_en <= 1'b0; out_din <= '0; Flush_Done <= 1'b0; Overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_wr && w_pop) r_count <= r_count - CNT_ONE;

      if (w_start) r_len <= w_start_len;
      if (r_state == S_HEAD) begin
        r_sum  <= '0;
        r_sent <= '0;
      end else if (w_pop) begin
        r_sum  <= r_sum + w_word;
        r_sent <= r_sent + 5'd1;
      end

      if (w_flush_done)                    r_seq <= '0;
      else if (w_emit && r_state == S_TAIL) r_seq <= r_seq + 8'd1;

      // A Test_Done arriving while a flush is already pending changes nothing.
      if (w_flush_done)   r_flush_pending <= 1'b0;
      else if (Test_Done) r_flush_pending <= 1'b1;

      out_wr_en  <= w_emit;
      if (w_emit) out_din <= w_word;
      Flush_Done <= w_flush_done;
      if (w_drop) Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scurve_usb_framer.sv
// Scoreboard bench for scurve_usb_framer: stimulus pushes expected USB words,
// a negedge monitor pops and compares whatever the DUT writes.
module tb_scurve_usb_framer;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Clear = 1'b0;
  logic        in_wr_en = 1'b0;
  logic [15:0] in_din = '0;
  logic        in_full;
  logic        Test_Done = 1'b0;
  logic [2:0]  Asic_ID = 3'd3;
  logic        out_wr_en;
  logic [15:0] out_din;
  logic        out_full = 1'b0;
  logic        Flush_Done;
  logic        Overflow;

  scurve_usb_framer dut (
    .Clk(Clk), .reset_n(reset_n), .Clear(Clear),
    .in_wr_en(in_wr_en), .in_din(in_din), .in_full(in_full),
    .Test_Done(Test_Done), .Asic_ID(Asic_ID),
    .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full),
    .Flush_Done(Flush_Done), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          n_seen = 0;
  int          exp_flush = 0;
  int          cyc = 0;
  int          last_tail_cyc = -100;
  logic        prev_full = 1'b0;
  logic [15:0] lfsr = 16'hACE1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge Clk) begin
    logic [15:0] w;
    cyc++;
    if (reset_n) begin
      if (out_wr_en) begin
        check("write_while_full", 32'(prev_full), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", out_din);
        end else begin
          w = exp_q.pop_front();
          check("frame_word", 32'(out_din), 32'(w));
          n_seen++;
          if (w == 16'h5AA5) last_tail_cyc = cyc;
        end
      end
      if (Flush_Done) begin
        if (exp_flush == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_flush_done: got 1 expected 0");
        end else begin
          exp_flush--;
          check("flush_done_delay", 32'(cyc - last_tail_cyc), 32'd1);
        end
      end
    end
    prev_full = out_full;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_seq(input logic [15:0] start, input logic [15:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      in_wr_en = 1'b1;
      in_din   = start + 16'(i) * step;
      tick();
    end
    in_wr_en = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [15:0] start,
                            input logic [15:0] step, input int n);
    logic [15:0] s;
    logic [15:0] w;
    s = '0;
    exp_q.push_back(16'hA55A);
    exp_q.push_back({Asic_ID, seq, 5'(n)});
    for (int i = 0; i < n; i++) begin
      w = start + 16'(i) * step;
      s = s + w;
      exp_q.push_back(w);
    end
    exp_q.push_back(s);
    exp_q.push_back(16'h5AA5);
  endtask

  task automatic pulse_done();
    Test_Done = 1'b1;
    tick();
    Test_Done = 1'b0;
  endtask

  task automatic drain(input string name, input int budget, input bit toggle);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_flush != 0) && n < budget) begin
      if (toggle) begin
        out_full = lfsr[0];
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      tick();
      n++;
    end
    out_full = 1'b0;
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
      exp_q.delete();
      exp_flush = 0;
    end
    repeat (10) tick();
  endtask

  task automatic wait_seen(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (n_seen < target && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d words expected %0d", name, n_seen, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out_wr_en"},  32'(out_wr_en),  32'd0);
    check({name, "_out_din"},    32'(out_din),    32'd0);
    check({name, "_in_full"},    32'(in_full),    32'd0);
    check({name, "_flush_done"}, 32'(Flush_Done), 32'd0);
    check({name, "_overflow"},   32'(Overflow),   32'd0);
  endtask

  initial begin
    int base;
    #12;
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Full 16-word frame, hand-computed words.
    exp_q.push_back(16'hA55A);
    exp_q.push_back(16'h6010);
    for (int i = 1; i <= 16; i++) exp_q.push_back(16'(i));
    exp_q.push_back(16'h0088);
    exp_q.push_back(16'h5AA5);
    write_seq(16'h0001, 16'h0001, 16);
    drain("full_frame", 200, 1'b0);

    // Partial frame on Test_Done: 1111..5555, checksum FFFF, seq 1.
    push_frame(8'd1, 16'h1111, 16'h1111, 5);
    exp_flush = 1;
    write_seq(16'h1111, 16'h1111, 5);
    repeat (3) tick();
    pulse_done();
    drain("partial_flush", 200, 1'b0);

    // Backpressure toggling; seq restarted at 0 by the flush.
    Asic_ID = 3'd5;
    push_frame(8'd0, 16'h0101, 16'h0001, 16);
    write_seq(16'h0101, 16'h0001, 16);
    drain("backpressure", 400, 1'b1);

    // Overflow: 40 words with the USB FIFO full.
    Asic_ID  = 3'd3;
    out_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_wr_en = 1'b1;
      in_din   = 16'h0201 + 16'(i);
      tick();
      if (i == 28) check("in_full_at_29", 32'(in_full), 32'd0);
      if (i == 29) check("in_full_at_30", 32'(in_full), 32'd1);
      if (i == 31) check("overflow_at_32", 32'(Overflow), 32'd0);
      if (i == 32) check("overflow_at_33", 32'(Overflow), 32'd1);
    end
    in_wr_en = 1'b0;
    push_frame(8'd1, 16'h0201, 16'h0001, 16);
    push_frame(8'd2, 16'h0211, 16'h0001, 16);
    out_full = 1'b0;
    drain("overflow_frames", 300, 1'b0);
    check("in_full_drained", 32'(in_full), 32'd0);
    check("overflow_sticky", 32'(Overflow), 32'd1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("overflow_cleared", 32'(Overflow), 32'd0);

    // Test_Done mid-DATA: frame completes, partial follows, then Flush_Done.
    base = n_seen;
    push_frame(8'd0, 16'h0301, 16'h0001, 16);
    write_seq(16'h0301, 16'h0001, 16);
    wait_seen("mid_data", base + 6, 100);
    push_frame(8'd1, 16'h0401, 16'h0001, 5);
    exp_flush = 1;
    write_seq(16'h0401, 16'h0001, 5);
    pulse_done();
    tick();
    pulse_done();
    drain("mid_flush", 300, 1'b0);

    // Reset mid-DATA of the second frame, then a clean frame with seq 0.
    base = n_seen;
    push_frame(8'd0, 16'h0501, 16'h0001, 16);
    push_frame(8'd1, 16'h0511, 16'h0001, 16);
    write_seq(16'h0501, 16'h0001, 32);
    wait_seen("pre_reset", base + 20 + 8, 200);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    push_frame(8'd0, 16'h0601, 16'h0001, 16);
    write_seq(16'h0601, 16'h0001, 16);
    drain("after_reset", 200, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
